// File: rtl/prbs_burst_ctrl_if.sv
// Command/stream bundle for prbs_burst_ctrl: command request, abort,
// and the valid/ready PRBS word stream with status pulses.
interface prbs_burst_ctrl_if #(
    parameter int unsigned LN = 8,
    parameter int unsigned OW = 8,
    parameter int unsigned LW = 16
) ();
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [LN-1:0] i_cmd_seed;
    logic [LW-1:0] i_cmd_len;
    logic          i_abort;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_last;
    logic          o_busy;
    logic          o_done;

    // Sequencer / consumer side.
    modport master (
        output i_cmd_valid, i_cmd_seed, i_cmd_len, i_abort, i_ready,
        input  o_cmd_ready, o_valid, o_data, o_last, o_busy, o_done
    );

    // Generator side.
    modport slave (
        input  i_cmd_valid, i_cmd_seed, i_cmd_len, i_abort, i_ready,
        output o_cmd_ready, o_valid, o_data, o_last, o_busy, o_done
    );
endinterface

// File: rtl/prbs_burst_ctrl.sv
// Galois PRBS burst generator: seeds the LFSR per command, packs one bit
// per clock LSB-first into OW-bit words, and streams them with backpressure.
module prbs_burst_ctrl #(
    parameter int unsigned   LN   = 8,
    parameter logic [LN-1:0] TAPS = 8'hb4,
    parameter int unsigned   OW   = 8,
    parameter int unsigned   LW   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    prbs_burst_ctrl_if.slave bus
);
    localparam int unsigned BW = (OW > 1) ? $clog2(OW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        OUT
    } state_t;

    state_t        state_q, state_d;
    logic [LN-1:0] sreg_q, sreg_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        remaining_d = remaining_q;
        bitcnt_d    = bitcnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    sreg_d      = (bus.i_cmd_seed == '0) ? LN'(1) : bus.i_cmd_seed;
                    remaining_d = bus.i_cmd_len;
                    bitcnt_d    = '0;
                    if (bus.i_cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (bus.i_abort) begin
                    state_d  = IDLE;
                    bitcnt_d = '0;
                end else begin
                    sreg_d = (sreg_q >> 1) ^ (sreg_q[0] ? TAPS : '0);
                    // Shift in from the top so that after OW steps the first bit sits at [0].
                    data_d = (data_q >> 1) | (OW'(sreg_q[0]) << (OW - 1));
                    if (bitcnt_q == BW'(OW - 1)) begin
                        state_d  = OUT;
                        bitcnt_d = '0;
                        valid_d  = 1'b1;
                        last_d   = (remaining_q == LW'(1));
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end

            OUT: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (bus.i_ready) begin
                    remaining_d = remaining_q - LW'(1);
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    if (remaining_q == LW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            sreg_q      <= LN'(1);
            remaining_q <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            remaining_q <= remaining_d;
            bitcnt_q    <= bitcnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_cmd_ready = (state_q == IDLE);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_last      = last_q;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Scoreboard bench for prbs_burst_ctrl: default instance (OW=8, LW=16) plus a
// narrow instance (OW=1, LW=4) for the minimum-width and full-length cases.
module tb_prbs_burst_ctrl;
    logic clk;
    logic rst;

    prbs_burst_ctrl_if #(.LN(8), .OW(8), .LW(16)) bus ();
    prbs_burst_ctrl_if #(.LN(8), .OW(1), .LW(4))  bus2 ();

    prbs_burst_ctrl #(.LN(8), .TAPS(8'hb4), .OW(8), .LW(16)) u_dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    prbs_burst_ctrl #(.LN(8), .TAPS(8'hb4), .OW(1), .LW(4)) u_dut2 (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus2)
    );

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        if (s[0]) lfsr_next = (s >> 1) ^ 8'hb4;
        else      lfsr_next = s >> 1;
    endfunction

    // Pushes {last, word} for a burst of n words, ow bits each.
    task automatic model_push(input logic [7:0] seed, input int n, input int ow);
        logic [7:0] s;
        logic [7:0] w;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int b = 0; b < ow; b++) begin
                w[b] = s[0];
                s = lfsr_next(s);
            end
            exp_q.push_back({(k == n - 1), w});
        end
    endtask

    task automatic issue(input logic [7:0] seed, input logic [15:0] len);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_seed  = seed;
        bus.i_cmd_len   = len;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_cmd_ready, bus.o_valid, bus.o_busy, bus.o_done, bus.o_last, bus.o_data} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL reset_held: got rdy/vld/busy/done/last=%b data=%h, want 10000 data=00",
                     {bus.o_cmd_ready, bus.o_valid, bus.o_busy, bus.o_done, bus.o_last}, bus.o_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_cmd_ready, bus.o_valid, bus.o_busy, bus.o_done, bus2.o_cmd_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL reset_released: got rdy/vld/busy/done/rdy2=%b, want 10001",
                     {bus.o_cmd_ready, bus.o_valid, bus.o_busy, bus.o_done, bus2.o_cmd_ready});
        end
    endtask

    task automatic test_single;
        int cyc;
        logic [8:0] e;
        bus.i_ready = 1'b1;
        model_push(8'h01, 1, 8);
        issue(8'h01, 16'd1);
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, want 8", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL single_word: got last=%b data=%h, want last=%b data=%h", bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_done, bus.o_valid, bus.o_busy, bus.o_cmd_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL single_done: got done/vld/busy/rdy=%b, want 1001",
                     {bus.o_done, bus.o_valid, bus.o_busy, bus.o_cmd_ready});
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width: got done=%b, want 0", bus.o_done);
        end
    endtask

    task automatic test_two_words;
        int cyc;
        logic [8:0] e;
        bus.i_ready = 1'b1;
        model_push(8'h01, 2, 8);
        issue(8'h01, 16'd2);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL two_word1: got lat=%0d last=%b data=%h, want lat=8 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL two_spacing: got %0d cycles, want 9", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL two_word2: got last=%b data=%h, want last=%b data=%h", bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b1) begin
            errors++;
            $display("FAIL two_done: got done=%b, want 1", bus.o_done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int cyc;
        int bad;
        logic [8:0] e;
        bus.i_ready = 1'b0;
        model_push(8'h01, 2, 8);
        issue(8'h01, 16'd2);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL bp_word1: got lat=%0d last=%b data=%h, want lat=8 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(bus.o_valid === 1'b1 && {bus.o_last, bus.o_data} === e && bus.o_busy === 1'b1)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles of 20, want 0", bad);
        end
        bus.i_ready = 1'b1;
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 9 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL bp_word2: got lat=%0d last=%b data=%h, want lat=9 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_edge_cmds;
        int cyc;
        int bad;
        logic [8:0] e;
        bus.i_ready = 1'b1;
        model_push(8'h00, 1, 8);
        issue(8'h00, 16'd1);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL seed0_word: got lat=%0d last=%b data=%h, want lat=8 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
        issue(8'h33, 16'd0);
        checks++;
        if ({bus.o_done, bus.o_valid, bus.o_busy, bus.o_cmd_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL len0_done: got done/vld/busy/rdy=%b, want 1001",
                     {bus.o_done, bus.o_valid, bus.o_busy, bus.o_cmd_ready});
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL len0_quiet: got %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_abort;
        int cyc;
        int bad;
        logic [8:0] e;
        // Abort during FILL of word 2.
        bus.i_ready = 1'b1;
        model_push(8'h01, 2, 8);
        issue(8'h01, 16'd2);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL abort_fill_word1: got last=%b data=%h, want last=%b data=%h", bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        checks++;
        if ({bus.o_busy, bus.o_valid, bus.o_done, bus.o_cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_fill: got busy/vld/done/rdy=%b, want 0001",
                     {bus.o_busy, bus.o_valid, bus.o_done, bus.o_cmd_ready});
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_fill_quiet: got %0d active cycles, want 0", bad);
        end
        // Abort together with a handshake in OUT.
        bus.i_ready = 1'b0;
        model_push(8'h01, 2, 8);
        issue(8'h01, 16'd2);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL abort_out_word1: got lat=%0d data=%h, want lat=8 data=%h", cyc, bus.o_data, e[7:0]);
        end
        exp_q.delete();
        bus.i_abort = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        checks++;
        if ({bus.o_busy, bus.o_valid, bus.o_done, bus.o_cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_out: got busy/vld/done/rdy=%b, want 0001",
                     {bus.o_busy, bus.o_valid, bus.o_done, bus.o_cmd_ready});
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_out_quiet: got %0d active cycles, want 0", bad);
        end
        model_push(8'h01, 1, 8);
        issue(8'h01, 16'd1);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d last=%b data=%h, want lat=8 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [8:0] e;
        bus.i_ready = 1'b1;
        model_push(8'h01, 1, 8);
        issue(8'h01, 16'd2);
        wait_valid(cyc);
        e = exp_q.pop_front();
        // First command was len=2; only word 1 is expected before re-issuing.
        e[8] = 1'b0;
        checks++;
        if ({bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL b2b_word_a: got last=%b data=%h, want last=%b data=%h", bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        wait_valid(cyc);
        checks++;
        if (bus.o_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_a: got last=%b, want 1", bus.o_last);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_done, bus.o_cmd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done: got done/rdy=%b, want 11", {bus.o_done, bus.o_cmd_ready});
        end
        model_push(8'h01, 1, 8);
        issue(8'h01, 16'd1);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 8 || {bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL b2b_word_b: got lat=%0d last=%b data=%h, want lat=8 last=%b data=%h",
                     cyc, bus.o_last, bus.o_data, e[8], e[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_max_len;
        int nw;
        int bad;
        logic got_done;
        logic [8:0] e;
        bus2.i_ready = 1'b1;
        model_push(8'h5a, 15, 1);
        bus2.i_cmd_valid = 1'b1;
        bus2.i_cmd_seed  = 8'h5a;
        bus2.i_cmd_len   = 4'd15;
        @(negedge clk);
        bus2.i_cmd_valid = 1'b0;
        nw = 0;
        bad = 0;
        got_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus2.o_valid === 1'b1) begin
                nw++;
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    e = exp_q.pop_front();
                    if ({bus2.o_last, 7'b0, bus2.o_data} !== e) bad++;
                end
            end
            if (bus2.o_done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL maxlen_words: got %0d wrong words, want 0", bad);
        end
        checks++;
        if (nw !== 15 || got_done !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_count: got words=%0d done=%b, want words=15 done=1", nw, got_done);
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int cyc;
        bus.i_ready = 1'b0;
        issue(8'h01, 16'd1);
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL areset_setup: got lat=%0d, want 8", cyc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL areset_immediate: got vld/busy/rdy=%b, want 001",
                     {bus.o_valid, bus.o_busy, bus.o_cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_cmd_ready, bus.o_valid, bus.o_busy, bus.o_data} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL areset_release: got rdy/vld/busy=%b data=%h, want 100 data=00",
                     {bus.o_cmd_ready, bus.o_valid, bus.o_busy}, bus.o_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_seed   = '0;
        bus.i_cmd_len    = '0;
        bus.i_abort      = 1'b0;
        bus.i_ready      = 1'b0;
        bus2.i_cmd_valid = 1'b0;
        bus2.i_cmd_seed  = '0;
        bus2.i_cmd_len   = '0;
        bus2.i_abort     = 1'b0;
        bus2.i_ready     = 1'b0;

        test_reset();
        test_single();
        test_two_words();
        test_backpressure();
        test_edge_cmds();
        test_abort();
        test_back_to_back();
        test_max_len();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prbs_burst_ctrl.md
# prbs_burst_ctrl

Burst controller for a Galois-form PRBS generator. It accepts a command holding a seed and a word count. It loads the seed, steps the LFSR one bit per clock, and packs the bits LSB-first into OW-bit words. The words go out on a valid/ready stream with backpressure. The block sits between a test/stimulus sequencer and any consumer of pseudo-random data, such as a filter test bench or a channel scrambler check.

## Interface
- LN, 8, LFSR length / polynomial degree.
- TAPS, 8'hb4, Galois tap mask, LN bits.
- OW, 8, output word width; OW >= 1.
- LW, 16, width of the word-count field.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command can be accepted. High only in IDLE.
- i_cmd_seed  in  LN  LFSR seed. Zero is replaced by 1.
- i_cmd_len  in  LW  number of words to produce. Zero is legal.
- i_abort  in  1  synchronous abort of the current burst.
- o_valid  out  1  o_data holds a finished word.
- i_ready  in  1  consumer accepts the word.
- o_data  out  OW  packed PRBS word.
- o_last  out  1  qualifies o_valid: this is the final word of the burst.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse when a burst completes normally.

## Operation
- States: IDLE, FILL, OUT.
- **IDLE**
  - o_cmd_ready = 1.
  - On i_cmd_valid, latch sreg <= (seed==0 ? 1 : seed) and remaining <= i_cmd_len.
  - If len != 0, go to FILL with bitcnt = 0. If len == 0, pulse o_done next cycle and stay in IDLE.
- **LFSR step** (FILL only, one per cycle)
  - The output bit is sreg[0].
  - sreg <= {1'b0, sreg[LN-1:1]} ^ (sreg[0] ? TAPS : 0).
- **FILL**
  - Bit k of the word goes to o_data[k]; the first bit lands in o_data[0].
  - After OW steps (bitcnt == OW-1), go to OUT.
  - Raise o_valid. Set o_last = (remaining == 1).
- **OUT**
  - The LFSR is frozen. o_data, o_valid and o_last hold stable until i_ready.
  - On i_ready, decrement remaining.
    - If it was 1: go to IDLE and pulse o_done.
    - Otherwise: go to FILL.
- **LFSR continuity**: state carries between words of one burst. A new command always reloads the seed.
- **i_abort**
  - In FILL or OUT: go to IDLE the next cycle. Drop any pending word (o_valid falls), and give no o_done.
  - In IDLE: ignored.
  - Abort takes priority over a simultaneous i_ready handshake.
- **Reset**
  - Values: state = IDLE, sreg = 1, remaining = 0, bitcnt = 0, o_data = 0.
  - Outputs: o_valid = 0, o_last = 0, o_done = 0, o_busy = 0, o_cmd_ready = 1.
  - Reset mid-burst discards everything immediately (asynchronous).
- **Widths**: remaining is LW bits. A length of 2^LW-1 must complete without wrap. bitcnt is clog2(OW) bits, minimum 1.

## Timing
- All outputs are registered; o_cmd_ready and o_busy decode directly from state.
- Command accepted at edge E0:
  - FILL steps occur at E1..E(OW).
  - o_valid is high after E(OW). First-word latency is OW cycles from acceptance.
- Handshake at edge H:
  - If more words remain, the next o_valid rises after H+OW.
  - With i_ready held high, throughput is one word per OW+1 cycles.
- o_done is high for exactly the one cycle after the final handshake edge, or after a zero-length acceptance. o_cmd_ready is high in that same cycle.
- A back-to-back command may be accepted in the cycle o_done is high.
- o_valid never drops without a handshake, except on abort or reset.

## Test plan
- **Single word, defaults.** seed=8'h01, len=1, i_ready=1.
  - o_valid rises 8 cycles after acceptance with o_data=8'h29 and o_last=1.
  - o_done pulses one cycle after the handshake.
- **Two words.** seed=8'h01, len=2.
  - Words are 8'h29 then 8'hFF.
  - o_last is 0 then 1. The second o_valid rises 9 cycles after the first.
- **Backpressure.** Hold i_ready=0 for 20 cycles on word 1.
  - o_data stays 8'h29 and o_valid stays high throughout.
  - Word 2 is still 8'hFF, which shows the LFSR froze.
- **Edge commands.**
  - seed=0 gives output identical to seed=1.
  - len=0 gives no o_valid, an o_done pulse one cycle after acceptance, and o_cmd_ready back at 1.
- **Abort.** Assert i_abort during FILL of word 2, and separately together with i_ready in OUT.
  - In both cases the next cycle has IDLE, o_valid=0 and no o_done.
  - A following command with seed=1 yields 8'h29.
- **Async reset.** Assert i_reset between clock edges during OUT.
  - o_valid=0 and o_busy=0 immediately, without waiting for a clock edge.
  - After release, o_cmd_ready=1.
